// File: rtl/enum_index_table_feeder.sv
// Feeder for the enum-indexed lookup stage. It loads a DEPTH-word table and then
// serves select queries through a one-deep registered result slot.
module enum_index_table_feeder #(
    parameter int WORD_W = 32,
    parameter int DEPTH  = 4,
    parameter int SEL_W  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [WORD_W-1:0]         wr_data,
    input  logic                      clear,
    output logic                      loaded,
    input  logic                      q_valid,
    output logic                      q_ready,
    input  logic [SEL_W-1:0]          q_sel,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SEL_W-1:0]          out_sel,
    output logic [WORD_W*DEPTH-1:0]   out_arr,
    output logic                      out_oob
);

    typedef enum logic [0:0] {
        ST_LOAD  = 1'b0,
        ST_SERVE = 1'b1
    } state_t;

    localparam logic [SEL_W-1:0] LAST_ENTRY = SEL_W'(DEPTH - 1);
    localparam logic [SEL_W:0]   LAST_IDX   = (SEL_W + 1)'(DEPTH - 1);
    localparam logic [SEL_W:0]   IDX_ONE    = (SEL_W + 1)'(1);

    state_t                    state_r;
    state_t                    state_nxt_s;
    logic [SEL_W-1:0]          wr_count_r;
    logic [SEL_W-1:0]          wr_count_nxt_s;
    logic [WORD_W*DEPTH-1:0]   table_r;
    logic                      wr_fire_s;
    logic                      q_fire_s;
    logic                      oob_s;
    logic                      out_valid_r;
    logic [SEL_W-1:0]          out_sel_r;
    logic [WORD_W*DEPTH-1:0]   out_arr_r;
    logic                      out_oob_r;

    // Handshake readies; both are forced low while reset is asserted.
    assign wr_ready  = !rst && (state_r == ST_LOAD) && !clear;
    assign q_ready   = !rst && (state_r == ST_SERVE) && !clear && (!out_valid_r || out_ready);
    assign wr_fire_s = wr_valid && wr_ready;
    assign q_fire_s  = q_valid && q_ready;
    assign loaded    = (state_r == ST_SERVE);

    // The lookup stage reads entry sel+1; flag it when that index would need clamping.
    assign oob_s = ({1'b0, q_sel} + IDX_ONE) > LAST_IDX;

    assign out_valid = out_valid_r;
    assign out_sel   = out_sel_r;
    assign out_arr   = out_arr_r;
    assign out_oob   = out_oob_r;

    // Next-state and write-pointer logic for the load/serve sequencer.
    always_comb begin
        state_nxt_s    = state_r;
        wr_count_nxt_s = wr_count_r;
        case (state_r)
            ST_LOAD: begin
                if (clear) begin
                    wr_count_nxt_s = '0;
                end else if (wr_fire_s) begin
                    if (wr_count_r == LAST_ENTRY) begin
                        state_nxt_s    = ST_SERVE;
                        wr_count_nxt_s = '0;
                    end else begin
                        wr_count_nxt_s = wr_count_r + SEL_W'(1);
                    end
                end else begin
                    wr_count_nxt_s = wr_count_r;
                end
            end
            ST_SERVE: begin
                if (clear) begin
                    state_nxt_s    = ST_LOAD;
                    wr_count_nxt_s = '0;
                end else begin
                    state_nxt_s = ST_SERVE;
                end
            end
            default: begin
                state_nxt_s    = ST_LOAD;
                wr_count_nxt_s = '0;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_LOAD;
            wr_count_r <= '0;
        end else begin
            state_r    <= state_nxt_s;
            wr_count_r <= wr_count_nxt_s;
        end
    end

    // Table storage; a clear leaves partially written entries in place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            table_r <= '0;
        end else if (wr_fire_s) begin
            table_r[WORD_W*int'(wr_count_r) +: WORD_W] <= wr_data;
        end
    end

    // Result slot: the snapshot is a copy, so later table loads cannot disturb it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_sel_r   <= '0;
            out_arr_r   <= '0;
            out_oob_r   <= 1'b0;
        end else if (q_fire_s) begin
            out_valid_r <= 1'b1;
            out_sel_r   <= q_sel;
            out_arr_r   <= table_r;
            out_oob_r   <= oob_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_enum_index_table_feeder.sv
// Directed bench for enum_index_table_feeder: table load, queries, stalls,
// clear while a result is held, partial load then clear, and async reset.
module tb_enum_index_table_feeder;

    logic         clk = 1'b0;
    logic         rst;
    logic         wr_valid;
    logic         wr_ready;
    logic [31:0]  wr_data;
    logic         clear;
    logic         loaded;
    logic         q_valid;
    logic         q_ready;
    logic [1:0]   q_sel;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   out_sel;
    logic [127:0] out_arr;
    logic         out_oob;

    int errors = 0;
    int checks = 0;

    localparam logic [127:0] TBL_A = {32'h44, 32'h33, 32'h22, 32'h11};
    localparam logic [127:0] TBL_C = {32'h8, 32'h7, 32'h6, 32'h5};

    enum_index_table_feeder #(.WORD_W(32), .DEPTH(4), .SEL_W(2)) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_data(wr_data), .clear(clear), .loaded(loaded), .q_valid(q_valid),
        .q_ready(q_ready), .q_sel(q_sel), .out_valid(out_valid),
        .out_ready(out_ready), .out_sel(out_sel), .out_arr(out_arr), .out_oob(out_oob)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [31:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        step();
        wr_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr_valid = 1'b0; wr_data = '0; clear = 1'b0;
        q_valid = 1'b0; q_sel = '0; out_ready = 1'b0;
        step();
        chk("rst_wr_ready", 128'(wr_ready), 128'(0));
        chk("rst_q_ready", 128'(q_ready), 128'(0));
        chk("rst_loaded", 128'(loaded), 128'(0));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_sel", 128'(out_sel), 128'(0));
        chk("rst_out_arr", out_arr, 128'(0));
        chk("rst_out_oob", 128'(out_oob), 128'(0));
        rst = 1'b0;
        #1;
        chk("load_wr_ready", 128'(wr_ready), 128'(1));

        write_word(32'h11); write_word(32'h22); write_word(32'h33); write_word(32'h44);
        chk("loaded_after_4", 128'(loaded), 128'(1));
        chk("wr_ready_serve", 128'(wr_ready), 128'(0));

        // Query sel=1
        out_ready = 1'b1; q_valid = 1'b1; q_sel = 2'd1;
        #1;
        chk("q_ready_idle", 128'(q_ready), 128'(1));
        step();
        q_valid = 1'b0;
        chk("q1_valid", 128'(out_valid), 128'(1));
        chk("q1_sel", 128'(out_sel), 128'(1));
        chk("q1_arr", out_arr, TBL_A);
        chk("q1_oob", 128'(out_oob), 128'(0));

        // Query sel=3: index 4 would exceed 3
        q_valid = 1'b1; q_sel = 2'd3;
        step();
        q_valid = 1'b0;
        chk("q3_sel", 128'(out_sel), 128'(3));
        chk("q3_oob", 128'(out_oob), 128'(1));
        step();
        chk("drain_valid", 128'(out_valid), 128'(0));
        chk("drain_sel_kept", 128'(out_sel), 128'(3));

        // Stream 0..3 with a 3-cycle stall on the first result
        out_ready = 1'b0; q_valid = 1'b1; q_sel = 2'd0;
        step();
        q_sel = 2'd1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_q_ready", 128'(q_ready), 128'(0));
            chk("stall_valid", 128'(out_valid), 128'(1));
            chk("stall_sel", 128'(out_sel), 128'(0));
            chk("stall_oob", 128'(out_oob), 128'(0));
            step();
        end
        out_ready = 1'b1;
        step();
        chk("stream_sel1", 128'(out_sel), 128'(1));
        chk("stream_valid1", 128'(out_valid), 128'(1));
        q_sel = 2'd2;
        step();
        chk("stream_sel2", 128'(out_sel), 128'(2));
        chk("stream_oob2", 128'(out_oob), 128'(0));
        q_sel = 2'd3;
        step();
        q_valid = 1'b0;
        chk("stream_sel3", 128'(out_sel), 128'(3));
        chk("stream_oob3", 128'(out_oob), 128'(1));
        step();
        chk("stream_done", 128'(out_valid), 128'(0));

        // Clear while a result is held
        out_ready = 1'b0; q_valid = 1'b1; q_sel = 2'd2;
        step();
        q_valid = 1'b0; clear = 1'b1;
        #1;
        chk("clear_q_ready", 128'(q_ready), 128'(0));
        chk("clear_wr_ready", 128'(wr_ready), 128'(0));
        step();
        clear = 1'b0;
        chk("clear_loaded", 128'(loaded), 128'(0));
        chk("clear_held_valid", 128'(out_valid), 128'(1));
        chk("clear_held_sel", 128'(out_sel), 128'(2));
        write_word(32'hA0); write_word(32'hA1); write_word(32'hA2); write_word(32'hA3);
        chk("reload_loaded", 128'(loaded), 128'(1));
        chk("held_arr_intact", out_arr, TBL_A);
        chk("held_valid_intact", 128'(out_valid), 128'(1));
        out_ready = 1'b1;
        step();
        chk("held_consumed", 128'(out_valid), 128'(0));

        // Partial load, clear, full reload
        clear = 1'b1;
        step();
        clear = 1'b0;
        write_word(32'h1); write_word(32'h2);
        chk("partial_not_loaded", 128'(loaded), 128'(0));
        clear = 1'b1;
        step();
        clear = 1'b0;
        write_word(32'h5); write_word(32'h6); write_word(32'h7); write_word(32'h8);
        chk("reload2_loaded", 128'(loaded), 128'(1));
        q_valid = 1'b1; q_sel = 2'd2;
        step();
        q_sel = 2'd0;
        chk("tblc_arr", out_arr, TBL_C);
        chk("tblc_oob", 128'(out_oob), 128'(0));
        chk("tblc_valid", 128'(out_valid), 128'(1));

        // Async reset in the middle of a cycle drops everything at once
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 128'(out_valid), 128'(0));
        chk("arst_out_arr", out_arr, 128'(0));
        chk("arst_loaded", 128'(loaded), 128'(0));
        chk("arst_wr_ready", 128'(wr_ready), 128'(0));
        chk("arst_q_ready", 128'(q_ready), 128'(0));
        q_valid = 1'b0;
        step();
        rst = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
